header_feeder: RTL and testbench

HEADER_FEEDER -- requirements
Module: header_feeder

---
 rtl/miner_pkg.sv | 9 +
 rtl/header_feeder_if.sv | 24 ++
 rtl/idle_watchdog.sv | 21 ++
 rtl/header_feeder.sv | 92 +++++++++
 tb/tb_header_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: constants and FSM state type shared by the header feeder blocks
//   HDR_WORDS  : words per block header (80 bytes)
//   START_CODE : code presented to the hashing core once a header is complete
//   state_e    : header feeder FSM states
package miner_pkg;
  localparam int HDR_WORDS = 20;
  localparam logic [3:0] START_CODE = 4'hA;
  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DRAIN, START, ERROR} state_e;
endpackage

// File: rtl/header_feeder_if.sv
// header_feeder_if: read-master command and show-ahead FIFO signals
//   master : feeder side (drives rd_go/rd_base/rd_length/rd_buffer)
//   slave  : read-master side (drives rd_done/rd_data/rd_data_available)
interface header_feeder_if #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH = 32
);
  logic rd_fixed_location;
  logic [ADDRESSWIDTH-1:0] rd_base;
  logic [ADDRESSWIDTH-1:0] rd_length;
  logic rd_go;
  logic rd_done;
  logic rd_buffer;
  logic [DATAWIDTH-1:0] rd_data;
  logic rd_data_available;
  modport master(
    output rd_fixed_location, rd_base, rd_length, rd_go, rd_buffer,
    input rd_done, rd_data, rd_data_available
  );
  modport slave(
    input rd_fixed_location, rd_base, rd_length, rd_go, rd_buffer,
    output rd_done, rd_data, rd_data_available
  );
endinterface

// File: rtl/idle_watchdog.sv
// idle_watchdog: counts enabled cycles and flags when the count reaches WDOG_MAX
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count from zero (wins over enable)
//   enable     : count this cycle
//   expired    : count has reached WDOG_MAX (count holds there)
module idle_watchdog #(
  parameter int WDOG_MAX = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [15:0] cnt_q;
  assign expired = cnt_q == 16'(WDOG_MAX);
  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + 16'd1;
  end
endmodule

// File: rtl/header_feeder.sv
// header_feeder: fetches one block header through a read master and streams it to the hashing core
//   clk, reset        : clock, synchronous active-high reset
//   cmd_go, cmd_base  : one-cycle fetch request and header byte address
//   busy, done, err   : activity, completion pulse, sticky error
//   rd                : read-master command and show-ahead FIFO (master side)
//   core_out, shift_out_enable, start_out, word_count : hashing-core feed
module header_feeder #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH = 32,
  parameter int HDR_WORDS = miner_pkg::HDR_WORDS,
  parameter int WDOG_MAX = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_go,
  input  logic [ADDRESSWIDTH-1:0] cmd_base,
  output logic busy,
  output logic done,
  output logic err,
  header_feeder_if.master rd,
  output logic [DATAWIDTH-1:0] core_out,
  output logic shift_out_enable,
  output logic [3:0] start_out,
  output logic [4:0] word_count
);
  import miner_pkg::*;
  localparam logic [4:0] LAST = 5'(HDR_WORDS - 1);
  state_e state_q, state_d;
  logic [ADDRESSWIDTH-1:0] base_q, len_q;
  logic [DATAWIDTH-1:0] core_q;
  logic shift_q, err_q, pop, short_rd, expired, accept;
  logic [4:0] wc_q;
  assign accept = state_q == IDLE && cmd_go;
  // combinational strobes are gated by reset so they drop in the reset cycle itself
  assign pop = !reset && state_q == STREAM && rd.rd_data_available && 32'(wc_q) < HDR_WORDS;
  assign short_rd = state_q == STREAM && !pop && rd.rd_done && !rd.rd_data_available;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_go ? ISSUE : IDLE;
      ISSUE:   state_d = STREAM;
      STREAM:  state_d = (pop && wc_q == LAST) ? DRAIN : (short_rd || expired) ? ERROR : STREAM;
      DRAIN:   state_d = rd.rd_done ? START : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      core_q <= '0;
      shift_q <= 1'b0;
      err_q <= 1'b0;
      wc_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= pop;
      if (pop) begin
        core_q <= rd.rd_data;
        wc_q <= wc_q + 5'd1;
      end
      if (accept) begin
        base_q <= cmd_base;
        len_q <= ADDRESSWIDTH'(HDR_WORDS * 4);
        err_q <= 1'b0;
        wc_q <= '0;
      end
      if (state_q == STREAM && state_d == ERROR) err_q <= 1'b1;
    end
  end
  // a pop or leaving STREAM restarts the idle count
  idle_watchdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
    .clk(clk),
    .reset(reset),
    .clear(state_q != STREAM || pop),
    .enable(state_q == STREAM && !pop),
    .expired(expired)
  );
  assign busy = !reset && state_q != IDLE;
  assign done = !reset && state_q == START;
  assign err = err_q;
  assign start_out = done ? START_CODE : 4'h0;
  assign rd.rd_fixed_location = 1'b0;
  assign rd.rd_base = base_q;
  assign rd.rd_length = len_q;
  assign rd.rd_go = !reset && state_q == ISSUE;
  assign rd.rd_buffer = pop;
  assign core_out = core_q;
  assign shift_out_enable = shift_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_header_feeder.sv
// tb_header_feeder: scoreboard bench for header_feeder with a show-ahead FIFO model
module tb_header_feeder;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int HW = 20;
  localparam int WD = 40;
  typedef struct packed {logic [DW-1:0] w; logic [4:0] idx;} word_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_go = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic busy, done, err, shift_out_enable;
  logic [DW-1:0] core_out;
  logic [3:0] start_out;
  logic [4:0] word_count;
  header_feeder_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) rif();
  header_feeder #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .HDR_WORDS(HW), .WDOG_MAX(WD)) dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go), .cmd_base(cmd_base),
    .busy(busy), .done(done), .err(err), .rd(rif.master),
    .core_out(core_out), .shift_out_enable(shift_out_enable),
    .start_out(start_out), .word_count(word_count)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] fifo[$];
  word_t exp_word[$];
  logic [2*AW-1:0] exp_rd[$];
  bit exp_end[$];
  int errors = 0, checks = 0, cyc = 0, shift_cyc = 0, done_cyc = 0;
  logic pop_pend = 1'b0;
  logic prev_err = 1'b0;
  logic [2*AW-1:0] er;
  word_t ew;
  bit ek;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // FIFO model: apply last cycle's pop, present the head, then sample the pop strobe
  initial begin
    rif.rd_data = '0;
    rif.rd_data_available = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_pend && fifo.size() > 0) fifo.delete(0);
      #1;
      rif.rd_data_available = fifo.size() > 0;
      rif.rd_data = fifo.size() > 0 ? fifo[0] : '0;
      #1;
      pop_pend = rif.rd_buffer;
      if (pop_pend) chk("pop_nonempty", rif.rd_data_available, 1);
    end
  end
  // monitor: pops the scoreboard whenever the DUT presents an event
  initial forever begin
    @(negedge clk);
    #3;
    cyc++;
    if (rif.rd_go) begin
      if (exp_rd.size() == 0) chk("rd_go_unexpected", 1, 0);
      else begin
        er = exp_rd.pop_front();
        chk("rd_base", rif.rd_base, er[2*AW-1:AW]);
        chk("rd_length", rif.rd_length, er[AW-1:0]);
      end
      chk("rd_fixed_location", rif.rd_fixed_location, 0);
    end
    if (shift_out_enable) begin
      shift_cyc = cyc;
      if (exp_word.size() == 0) chk("shift_unexpected", 1, 0);
      else begin
        ew = exp_word.pop_front();
        chk("core_out", core_out, ew.w);
        chk("word_count", word_count, ew.idx);
      end
    end
    if (done) begin
      done_cyc = cyc;
      if (exp_end.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        ek = exp_end.pop_front();
        chk("end_is_done", ek, 1);
        chk("start_code", start_out, 4'hA);
      end
    end else if (start_out != 4'h0) chk("start_out_idle", start_out, 0);
    if (err && !prev_err) begin
      if (exp_end.size() == 0) chk("err_unexpected", 1, 0);
      else begin
        ek = exp_end.pop_front();
        chk("end_is_err", ek, 0);
      end
    end
    prev_err = err;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_word(input logic [DW-1:0] v, input int idx);
    word_t t;
    t.w = v;
    t.idx = 5'(idx);
    fifo.push_back(v);
    exp_word.push_back(t);
  endtask
  task automatic load(input int n, input logic [DW-1:0] seed);
    for (int i = 0; i < n; i++) push_word(seed + DW'(i * 3), i + 1);
  endtask
  task automatic go(input logic [AW-1:0] b);
    exp_rd.push_back({b, AW'(HW * 4)});
    cmd_base = b;
    cmd_go = 1'b1;
    @(negedge clk);
    cmd_go = 1'b0;
  endtask
  task automatic wait_wc(input int n, input int budget);
    int k = 0;
    while (word_count != 5'(n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_word_count", word_count, n);
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", busy, 0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_go"}, rif.rd_go, 0);
    chk({tag, "_rd_buffer"}, rif.rd_buffer, 0);
    chk({tag, "_rd_base"}, rif.rd_base, 0);
    chk({tag, "_rd_length"}, rif.rd_length, 0);
    chk({tag, "_core_out"}, core_out, 0);
    chk({tag, "_shift"}, shift_out_enable, 0);
    chk({tag, "_start_out"}, start_out, 0);
    chk({tag, "_word_count"}, word_count, 0);
  endtask
  initial begin
    int t0;
    rif.rd_done = 1'b0;
    tick(3);
    check_zero("reset");
    reset = 1'b0;
    tick(2);
    chk("idle_busy", busy, 0);
    // full FIFO, DRAIN must hold until rd_done
    load(HW, 32'hA500_0000);
    go(28'h0000100);
    chk("busy_after_accept", busy, 1);
    wait_wc(HW, 60);
    tick(3);
    chk("drain_holds", busy, 1);
    rif.rd_done = 1'b1;
    exp_end.push_back(1'b1);
    wait_idle(10);
    chk("fifo_drained", fifo.size(), 0);
    rif.rd_done = 1'b0;
    tick(1);
    // gapped FIFO, rd_done already high at the last pop
    go(28'h0ABCDE0);
    for (int i = 0; i < HW; i++) begin
      tick(3);
      push_word(32'h5A00_0000 ^ DW'(i * 257), i + 1);
      if (i == HW - 1) begin
        rif.rd_done = 1'b1;
        exp_end.push_back(1'b1);
      end
    end
    wait_idle(20);
    chk("start_after_last_pop", done_cyc - shift_cyc, 1);
    rif.rd_done = 1'b0;
    tick(1);
    // short read after 12 words
    load(12, 32'h1234_0000);
    exp_end.push_back(1'b0);
    go(28'h0000200);
    wait_wc(12, 60);
    tick(1);
    rif.rd_done = 1'b1;
    wait_idle(10);
    chk("short_err", err, 1);
    chk("short_idle", busy, 0);
    rif.rd_done = 1'b0;
    tick(1);
    // watchdog with no data; the accept also clears the old error
    exp_end.push_back(1'b0);
    t0 = cyc;
    go(28'h0000300);
    chk("err_cleared", err, 0);
    wait_idle(WD + 20);
    chk("wdog_err", err, 1);
    chk("wdog_duration", (cyc - t0 >= WD && cyc - t0 <= WD + 6), 1);
    tick(1);
    // reset after word 7 with cmd_go held high throughout
    load(HW, 32'hC0DE_0000);
    exp_rd.push_back({28'h0002222, AW'(HW * 4)});
    cmd_base = 28'h0002222;
    cmd_go = 1'b1;
    wait_wc(7, 40);
    reset = 1'b1;
    cmd_go = 1'b0;
    tick(1);
    check_zero("midreset");
    reset = 1'b0;
    tick(3);
    chk("fifo_left", fifo.size(), HW - 7);
    chk("idle_after_reset", busy, 0);
    fifo.delete();
    exp_word.delete();
    tick(1);
    // recovery: normal header with rd_done high from the start
    rif.rd_done = 1'b1;
    load(HW, 32'h0F0F_0000);
    exp_end.push_back(1'b1);
    go(28'hFFFFF00);
    wait_idle(60);
    rif.rd_done = 1'b0;
    tick(2);
    chk("exp_rd_empty", exp_rd.size(), 0);
    chk("exp_word_empty", exp_word.size(), 0);
    chk("exp_end_empty", exp_end.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
